// File: rtl/floppy_timer_port_if.sv
// CPU I/O bus and timer load/status signals shared by the timer port and its surroundings.
interface floppy_timer_port_if;
   logic [7:0] cpu_addr;
   logic [7:0] cpu_di;
   logic       cpu_wr_n;
   logic [7:0] cpu_do;
   logic       cpu_sel;
   logic [7:0] tmr_di;
   logic       tmr_wren;
   logic [7:0] tmr_q;
   logic       irq;
   logic       irq_ack;

   // CPU/timer side: drives address, data, strobe, count and acknowledge
   modport master (
      output cpu_addr, cpu_di, cpu_wr_n, tmr_q, irq_ack,
      input  cpu_do, cpu_sel, tmr_di, tmr_wren, irq
   );

   // Port side: decodes the bus and drives the timer load and interrupt
   modport slave (
      input  cpu_addr, cpu_di, cpu_wr_n, tmr_q, irq_ack,
      output cpu_do, cpu_sel, tmr_di, tmr_wren, irq
   );
endinterface

// File: rtl/floppy_timer_port.sv
// Floppy-CPU front end for the 100 Hz countdown timer: 4-byte register window, one load
// pulse per write strobe, expiry latch with level IRQ and optional auto-reload.
module floppy_timer_port #(
   parameter logic [7:0] BASE_ADDR = 8'hE0
) (
   input logic                clk,
   input logic                reset_n,
   floppy_timer_port_if.slave bus
);

   logic [7:0] tmr_di_q, tmr_di_d;
   logic       tmr_wren_q, tmr_wren_d;
   logic       ien_q, ien_d;
   logic       arl_q, arl_d;
   logic [7:0] reload_q, reload_d;
   logic       armed_q, armed_d;
   logic       expired_q, expired_d;
   logic [7:0] q_prev_q, q_prev_d;
   logic       wr_prev_q, wr_prev_d;

   logic       sel;
   logic [1:0] off;
   logic       commit;
   logic       commit_load;
   logic       expiry;

   assign sel         = (bus.cpu_addr[7:2] == BASE_ADDR[7:2]);
   assign off         = bus.cpu_addr[1:0];
   // Falling edge of the strobe only; wr_prev resets to 0 so a strobe held through reset is ignored
   assign commit      = wr_prev_q && !bus.cpu_wr_n && sel;
   assign commit_load = commit && (off == 2'd0);
   // The count reaching zero right after our own load pulse is not an expiry
   assign expiry      = armed_q && (q_prev_q != 8'd0) && (bus.tmr_q == 8'd0) && !tmr_wren_q;

   assign bus.cpu_sel  = sel;
   assign bus.tmr_di   = tmr_di_q;
   assign bus.tmr_wren = tmr_wren_q;
   assign bus.irq      = expired_q & ien_q;

   // Read-back mux, no side effects
   always_comb begin
      bus.cpu_do = 8'hFF;
      if (sel) begin
         case (off)
            2'd0:    bus.cpu_do = bus.tmr_q;
            2'd1:    bus.cpu_do = {expired_q, armed_q, 4'b0000, arl_q, ien_q};
            2'd2:    bus.cpu_do = reload_q;
            default: bus.cpu_do = 8'hFF;
         endcase
      end
   end

   // Next-state: CPU writes, then clears, then expiry (set wins over clears, CPU load wins over reload)
   always_comb begin
      tmr_di_d   = tmr_di_q;
      tmr_wren_d = 1'b0;
      ien_d      = ien_q;
      arl_d      = arl_q;
      reload_d   = reload_q;
      armed_d    = armed_q;
      expired_d  = expired_q;
      q_prev_d   = bus.tmr_q;
      wr_prev_d  = bus.cpu_wr_n;

      if (commit) begin
         case (off)
            2'd0: begin
               tmr_di_d   = bus.cpu_di;
               tmr_wren_d = 1'b1;
               armed_d    = (bus.cpu_di != 8'd0);
               expired_d  = 1'b0;
            end
            2'd1: begin
               ien_d = bus.cpu_di[0];
               arl_d = bus.cpu_di[1];
               if (bus.cpu_di[7]) begin
                  expired_d = 1'b0;
               end
            end
            2'd2:    reload_d = bus.cpu_di;
            default: ;
         endcase
      end

      if (bus.irq_ack) begin
         expired_d = 1'b0;
      end

      if (expiry) begin
         expired_d = 1'b1;
         if (!commit_load) begin
            if (arl_q && (reload_q != 8'd0)) begin
               tmr_di_d   = reload_q;
               tmr_wren_d = 1'b1;
            end else begin
               armed_d = 1'b0;
            end
         end
      end
   end

   // State registers, asynchronous clear cancels any pending load pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmr_di_q   <= 8'd0;
         tmr_wren_q <= 1'b0;
         ien_q      <= 1'b0;
         arl_q      <= 1'b0;
         reload_q   <= 8'd0;
         armed_q    <= 1'b0;
         expired_q  <= 1'b0;
         q_prev_q   <= 8'd0;
         wr_prev_q  <= 1'b0;
      end else begin
         tmr_di_q   <= tmr_di_d;
         tmr_wren_q <= tmr_wren_d;
         ien_q      <= ien_d;
         arl_q      <= arl_d;
         reload_q   <= reload_d;
         armed_q    <= armed_d;
         expired_q  <= expired_d;
         q_prev_q   <= q_prev_d;
         wr_prev_q  <= wr_prev_d;
      end
   end

endmodule

// File: tb/tb_floppy_timer_port.sv
// Scoreboard bench: stimulus queues expected loads and read-backs, a negedge monitor checks them.
module tb_floppy_timer_port;

   typedef struct {
      string      name;
      logic [7:0] exp_do;
      logic       exp_irq;
      logic       exp_sel;
      logic       chk_di;
      logic [7:0] exp_di;
   } rd_exp_t;

   logic       clk;
   logic       reset_n;
   logic [7:0] tq;
   logic       tick;
   logic       rd_stb;
   logic       done;
   int         timeouts;
   int         checks;
   int         failures;
   logic       prev_wren;

   rd_exp_t    rd_q[$];
   logic [7:0] ld_q[$];

   floppy_timer_port_if bus ();

   floppy_timer_port #(
      .BASE_ADDR(8'hE0)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Timer model: load on pulse, otherwise count down while ticking, stop at zero
   initial tq = 8'd0;
   always @(posedge clk) begin
      if (bus.tmr_wren) tq <= bus.tmr_di;
      else if (tick && tq != 8'd0) tq <= tq - 8'd1;
   end
   assign bus.tmr_q = tq;

   function automatic void chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endfunction

   // Monitor: compares read-backs on rd_stb and every load pulse against the scoreboard
   always @(negedge clk) begin
      rd_exp_t r;
      if (rd_stb) begin
         if (rd_q.size() == 0) begin
            chk("rd_queue_underflow", 8'd1, 8'd0);
         end else begin
            r = rd_q.pop_front();
            chk({r.name, "_do"}, bus.cpu_do, r.exp_do);
            chk({r.name, "_irq"}, {7'd0, bus.irq}, {7'd0, r.exp_irq});
            chk({r.name, "_sel"}, {7'd0, bus.cpu_sel}, {7'd0, r.exp_sel});
            if (r.chk_di) begin
               chk({r.name, "_tmr_di"}, bus.tmr_di, r.exp_di);
               chk({r.name, "_tmr_wren"}, {7'd0, bus.tmr_wren}, 8'd0);
            end
         end
      end
      if (bus.tmr_wren) begin
         chk("wren_back_to_back", {7'd0, prev_wren}, 8'd0);
         if (ld_q.size() == 0) chk("unexpected_load_di", bus.tmr_di, 8'hxx);
         else chk("load_di", bus.tmr_di, ld_q.pop_front());
      end
      prev_wren = bus.tmr_wren;
      if (done) begin
         chk("loads_outstanding", 8'(ld_q.size()), 8'd0);
         chk("reads_outstanding", 8'(rd_q.size()), 8'd0);
         chk("wait_timeouts", 8'(timeouts), 8'd0);
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   task automatic wr(input logic [7:0] a, input logic [7:0] d, input int hold);
      @(posedge clk); #1;
      bus.cpu_addr = a;
      bus.cpu_di   = d;
      bus.cpu_wr_n = 1'b0;
      repeat (hold) @(posedge clk);
      #1;
      bus.cpu_wr_n = 1'b1;
      bus.cpu_addr = 8'h00;
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] e, input logic ei,
                     input logic cd, input logic [7:0] ed, input string nm);
      rd_exp_t r;
      @(posedge clk); #1;
      bus.cpu_addr = a;
      r.name    = nm;
      r.exp_do  = e;
      r.exp_irq = ei;
      r.exp_sel = (a[7:2] == 6'b111000);
      r.chk_di  = cd;
      r.exp_di  = ed;
      rd_q.push_back(r);
      rd_stb = 1'b1;
      @(posedge clk); #1;
      rd_stb = 1'b0;
      bus.cpu_addr = 8'h00;
   endtask

   task automatic ack();
      @(posedge clk); #1;
      bus.irq_ack = 1'b1;
      @(posedge clk); #1;
      bus.irq_ack = 1'b0;
   endtask

   // Tick until the model reaches zero; returns #1 after the edge where it did
   task automatic wait_zero();
      bit hit;
      hit  = 1'b0;
      tick = 1'b1;
      for (int i = 0; i < 40 && !hit; i++) begin
         @(posedge clk); #1;
         if (tq == 8'd0) hit = 1'b1;
      end
      tick = 1'b0;
      if (!hit) timeouts++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; failures = 0; timeouts = 0; prev_wren = 1'b0;
      reset_n = 1'b0; tick = 1'b0; rd_stb = 1'b0; done = 1'b0;
      bus.cpu_addr = 8'h00; bus.cpu_di = 8'h00; bus.cpu_wr_n = 1'b1; bus.irq_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // Reset state and decode
      rd(8'hE1, 8'h00, 1'b0, 1'b1, 8'h00, "rst_off1");
      rd(8'hE2, 8'h00, 1'b0, 1'b1, 8'h00, "rst_off2");
      rd(8'h10, 8'hFF, 1'b0, 1'b1, 8'h00, "nosel");
      rd(8'hE3, 8'hFF, 1'b0, 1'b0, 8'h00, "off3");

      // 1: long strobe gives a single load
      ld_q.push_back(8'h03);
      wr(8'hE0, 8'h03, 5);
      rd(8'hE1, 8'h40, 1'b0, 1'b0, 8'h00, "t1_off1");
      rd(8'hE0, 8'h03, 1'b0, 1'b0, 8'h00, "t1_off0");

      // 2: expiry raises irq, ack clears it
      wr(8'hE1, 8'h01, 1);
      ld_q.push_back(8'h03);
      wr(8'hE0, 8'h03, 1);
      rd(8'hE1, 8'h41, 1'b0, 1'b0, 8'h00, "t2_armed");
      wait_zero();
      rd(8'hE1, 8'h81, 1'b1, 1'b0, 8'h00, "t2_expired");
      ack();
      rd(8'hE1, 8'h01, 1'b0, 1'b0, 8'h00, "t2_acked");

      // 3: auto-reload
      wr(8'hE1, 8'h03, 1);
      wr(8'hE2, 8'h05, 1);
      rd(8'hE2, 8'h05, 1'b0, 1'b0, 8'h00, "t3_reload");
      ld_q.push_back(8'h02);
      wr(8'hE0, 8'h02, 1);
      ld_q.push_back(8'h05);
      wait_zero();
      rd(8'hE1, 8'hC3, 1'b1, 1'b0, 8'h00, "t3_status");
      rd(8'hE0, 8'h05, 1'b1, 1'b0, 8'h00, "t3_count");

      // 4: ack in the expiry cycle loses, W1C later clears
      ack();
      rd(8'hE1, 8'h43, 1'b0, 1'b0, 8'h00, "t4_pre");
      wr(8'hE1, 8'h01, 1);
      wait_zero();
      bus.irq_ack = 1'b1;
      @(posedge clk); #1;
      bus.irq_ack = 1'b0;
      rd(8'hE1, 8'h81, 1'b1, 1'b0, 8'h00, "t4_ack_vs_set");
      wr(8'hE1, 8'h80, 1);
      rd(8'hE1, 8'h00, 1'b0, 1'b0, 8'h00, "t4_w1c");

      // 5: zero load disarms; CPU load beats auto-reload
      ld_q.push_back(8'h00);
      wr(8'hE0, 8'h00, 1);
      rd(8'hE1, 8'h00, 1'b0, 1'b0, 8'h00, "t5_disarmed");
      tick = 1'b1;
      repeat (4) @(posedge clk);
      #1 tick = 1'b0;
      rd(8'hE1, 8'h00, 1'b0, 1'b0, 8'h00, "t5_no_expiry");
      wr(8'hE1, 8'h02, 1);
      ld_q.push_back(8'h02);
      wr(8'hE0, 8'h02, 1);
      wait_zero();
      bus.cpu_addr = 8'hE0;
      bus.cpu_di   = 8'h07;
      bus.cpu_wr_n = 1'b0;
      ld_q.push_back(8'h07);
      @(posedge clk); #1;
      bus.cpu_wr_n = 1'b1;
      bus.cpu_addr = 8'h00;
      rd(8'hE0, 8'h07, 1'b0, 1'b0, 8'h00, "t5_cpu_wins");

      // 6: reset during a strobe cancels the pulse and ignores the held strobe
      @(posedge clk); #1;
      bus.cpu_addr = 8'hE0;
      bus.cpu_di   = 8'h09;
      bus.cpu_wr_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bus.cpu_wr_n = 1'b1;
      bus.cpu_addr = 8'h00;
      rd(8'hE1, 8'h00, 1'b0, 1'b1, 8'h00, "t6_off1");
      rd(8'hE2, 8'h00, 1'b0, 1'b1, 8'h00, "t6_off2");

      repeat (2) @(posedge clk);
      #1 done = 1'b1;
   end

endmodule
